// File: rtl/wb_stage.sv
// wb_stage -- writeback stage of the integer pipeline.
//
// Takes one retiring instruction per mem_valid/mem_ready handshake. For
// non-loads the writeback value (ALU result, PC+4 or U-immediate) is
// registered at the accepting edge. For loads the stage parks in WAIT_LD
// until the data memory answers, then extracts, aligns and extends the
// requested byte/half/word. The result drives the register-file write port.
//
// Optional feature: define WB_RETIRE_CNT_EN to add the retire_count output
// (one increment per completed instruction, errored loads included).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   mem_valid/mem_ready handshake with the MEM stage
//   mem_rd, mem_regwrite destination register and write enable
//   mem_wb_sel          00 alu_out, 01 load, 10 pc+4, 11 u_imm
//   mem_funct3          load type
//   mem_alu_out         ALU result / load address
//   mem_pc, mem_u_imm   PC and U-type immediate
//   dmem_resp/rdata     data-memory read response and aligned word
//   WB_in/WB_rd/WB_load_regfile  register-file write port
//   wb_err              one-cycle pulse on misaligned or illegal load
//   retire_count        retired-instruction count (WB_RETIRE_CNT_EN only)
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_out,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic [XLEN-1:0]  mem_u_imm,
  input  logic             dmem_resp,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [XLEN-1:0]  WB_in,
  output logic [4:0]       WB_rd,
  output logic             WB_load_regfile,
  output logic             wb_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_count
`endif
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_WAIT_LD = 1'b1;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic [0:0]      r_state;
  logic [4:0]      r_ld_rd;
  logic            r_ld_we;
  logic [2:0]      r_ld_f3;
  logic [1:0]      r_ld_off;

  logic            w_accept;
  logic [XLEN-1:0] w_src;
  logic [XLEN:0]   w_ld;      // {error, aligned data}

  // Extract and extend load data; the top bit of the result flags a
  // misaligned access or an unsupported funct3.
  function automatic logic [XLEN:0] align_load(input logic [2:0]      f3,
                                               input logic [1:0]      off,
                                               input logic [XLEN-1:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [XLEN-1:0]    shifted;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  align_load = {1'b0, {(XLEN-8){b[7]}}, b};
      3'b100:  align_load = {1'b0, {(XLEN-8){1'b0}}, b};
      3'b001:  align_load = {off[0], {(XLEN-16){h[15]}}, h};
      3'b101:  align_load = {off[0], {(XLEN-16){1'b0}}, h};
      3'b010:  align_load = {|off, word};
      default: align_load = {1'b1, word};
    endcase
  endfunction

  assign mem_ready = (r_state == S_IDLE);
  assign w_accept  = mem_valid && mem_ready;
  assign w_ld      = align_load(r_ld_f3, r_ld_off, dmem_rdata);

  always_comb begin
    w_src = mem_u_imm;
    case (mem_wb_sel)
      SEL_ALU: w_src = mem_alu_out;
      SEL_PC4: w_src = mem_pc + XLEN'(4);
      default: w_src = mem_u_imm;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_ld_rd         <= '0;
      r_ld_we         <= 1'b0;
      r_ld_f3         <= '0;
      r_ld_off        <= '0;
      WB_in           <= '0;
      WB_rd           <= '0;
      WB_load_regfile <= 1'b0;
      wb_err          <= 1'b0;
    end else begin
      WB_load_regfile <= 1'b0;
      wb_err          <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (mem_wb_sel == SEL_LOAD) begin
              r_ld_rd  <= mem_rd;
              r_ld_we  <= mem_regwrite;
              r_ld_f3  <= mem_funct3;
              r_ld_off <= mem_alu_out[1:0];
              r_state  <= S_WAIT_LD;
            end else begin
              WB_in           <= w_src;
              WB_rd           <= mem_rd;
              WB_load_regfile <= mem_regwrite && (mem_rd != 5'd0);
            end
          end
        end
        default: begin
          if (dmem_resp) begin
            WB_in           <= w_ld[XLEN-1:0];
            WB_rd           <= r_ld_rd;
            WB_load_regfile <= !w_ld[XLEN] && r_ld_we && (r_ld_rd != 5'd0);
            wb_err          <= w_ld[XLEN];
            r_state         <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic w_retire;

  // Non-loads retire at acceptance, loads (errored or not) at the response.
  assign w_retire = (w_accept && (mem_wb_sel != SEL_LOAD)) ||
                    ((r_state == S_WAIT_LD) && dmem_resp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_count <= '0;
    else if (w_retire)
      retire_count <= retire_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_pc;
  logic [31:0] mem_u_imm;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic [31:0] WB_in;
  logic [4:0]  WB_rd;
  logic        WB_load_regfile;
  logic        wb_err;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
  int          exp_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_wb_sel(mem_wb_sel),
    .mem_funct3(mem_funct3), .mem_alu_out(mem_alu_out), .mem_pc(mem_pc),
    .mem_u_imm(mem_u_imm), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .WB_in(WB_in), .WB_rd(WB_rd), .WB_load_regfile(WB_load_regfile),
    .wb_err(wb_err)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] uimm;
    logic [31:0] rdata;
    logic [31:0] exp_in;
    logic        exp_we;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(string n, logic [1:0] s, logic [2:0] f, logic [4:0] r,
                              logic w, logic [31:0] a, logic [31:0] p, logic [31:0] u,
                              logic [31:0] d, logic [31:0] ei, logic ew, logic ee);
    vec_t v;
    v.name = n; v.sel = s; v.f3 = f; v.rd = r; v.we = w; v.alu = a; v.pc = p;
    v.uimm = u; v.rdata = d; v.exp_in = ei; v.exp_we = ew; v.exp_err = ee;
    return v;
  endfunction

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_rd = '0; mem_regwrite = 1'b0; mem_wb_sel = '0;
    mem_funct3 = '0; mem_alu_out = '0; mem_pc = '0; mem_u_imm = '0;
    dmem_resp = 1'b0; dmem_rdata = '0;
  endtask

  task automatic run_vec(input vec_t v, input int wait_cycles);
    @(negedge clk);
    mem_valid = 1'b1; mem_wb_sel = v.sel; mem_funct3 = v.f3; mem_rd = v.rd;
    mem_regwrite = v.we; mem_alu_out = v.alu; mem_pc = v.pc; mem_u_imm = v.uimm;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    if (v.sel != 2'b01) begin
`ifdef WB_RETIRE_CNT_EN
      exp_cnt++;
`endif
      if (v.exp_we) chk({v.name, " data"}, WB_in, v.exp_in);
      if (v.exp_we) chk({v.name, " rd"}, {27'd0, WB_rd}, {27'd0, v.rd});
      chk({v.name, " strobe"}, {31'd0, WB_load_regfile}, {31'd0, v.exp_we});
      @(posedge clk); #1;
      chk({v.name, " strobe one cycle"}, {31'd0, WB_load_regfile}, 32'd0);
    end else begin
      chk({v.name, " strobe while waiting"}, {31'd0, WB_load_regfile}, 32'd0);
      chk({v.name, " ready while waiting"}, {31'd0, mem_ready}, 32'd0);
      for (int i = 0; i < wait_cycles; i++) begin
        @(posedge clk); #1;
        chk({v.name, " ready held low"}, {31'd0, mem_ready}, 32'd0);
        chk({v.name, " no early strobe"}, {31'd0, WB_load_regfile}, 32'd0);
      end
      @(negedge clk);
      dmem_resp = 1'b1; dmem_rdata = v.rdata;
      @(posedge clk); #1;
      dmem_resp = 1'b0;
`ifdef WB_RETIRE_CNT_EN
      exp_cnt++;
`endif
      if (v.exp_we) chk({v.name, " data"}, WB_in, v.exp_in);
      chk({v.name, " strobe"}, {31'd0, WB_load_regfile}, {31'd0, v.exp_we});
      chk({v.name, " err"}, {31'd0, wb_err}, {31'd0, v.exp_err});
      chk({v.name, " ready after resp"}, {31'd0, mem_ready}, 32'd1);
      @(posedge clk); #1;
      chk({v.name, " strobe/err one cycle"}, {30'd0, WB_load_regfile, wb_err}, 32'd0);
    end
  endtask

  initial begin
    //            name      sel    f3      rd  we alu           pc            uimm          rdata         exp_in        we  err
    vecs[0]  = mk("alu",    2'b00, 3'b000, 5,  1, 32'h00001234, 32'h0,        32'h0,        32'h0,        32'h00001234, 1, 0);
    vecs[1]  = mk("jal",    2'b10, 3'b000, 1,  1, 32'h0,        32'hFFFFFFFC, 32'h0,        32'h0,        32'h00000000, 1, 0);
    vecs[2]  = mk("lui",    2'b11, 3'b000, 7,  1, 32'h0,        32'h0,        32'hABCDE000, 32'h0,        32'hABCDE000, 1, 0);
    vecs[3]  = mk("rd0",    2'b00, 3'b000, 0,  1, 32'h00000055, 32'h0,        32'h0,        32'h0,        32'h00000055, 0, 0);
    vecs[4]  = mk("nowe",   2'b00, 3'b000, 3,  0, 32'h00000066, 32'h0,        32'h0,        32'h0,        32'h00000066, 0, 0);
    vecs[5]  = mk("lb",     2'b01, 3'b000, 9,  1, 32'h00001003, 32'h0,        32'h0,        32'h80FF0000, 32'hFFFFFF80, 1, 0);
    vecs[6]  = mk("lbu",    2'b01, 3'b100, 10, 1, 32'h00001002, 32'h0,        32'h0,        32'h80FF0000, 32'h000000FF, 1, 0);
    vecs[7]  = mk("lhu",    2'b01, 3'b101, 11, 1, 32'h00002002, 32'h0,        32'h0,        32'hBEEF1234, 32'h0000BEEF, 1, 0);
    vecs[8]  = mk("lh",     2'b01, 3'b001, 12, 1, 32'h00002000, 32'h0,        32'h0,        32'h00008001, 32'hFFFF8001, 1, 0);
    vecs[9]  = mk("lw",     2'b01, 3'b010, 13, 1, 32'h00003000, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1, 0);
    vecs[10] = mk("lh_mis", 2'b01, 3'b001, 14, 1, 32'h00002001, 32'h0,        32'h0,        32'hBEEF1234, 32'h0,        0, 1);
    vecs[11] = mk("lw_mis", 2'b01, 3'b010, 15, 1, 32'h00003002, 32'h0,        32'h0,        32'hBEEF1234, 32'h0,        0, 1);
    vecs[12] = mk("f3_011", 2'b01, 3'b011, 16, 1, 32'h00003000, 32'h0,        32'h0,        32'hBEEF1234, 32'h0,        0, 1);
    vecs[13] = mk("lb_rd0", 2'b01, 3'b000, 0,  1, 32'h00001000, 32'h0,        32'h0,        32'h0000007F, 32'h0,        0, 0);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset WB_in", WB_in, 32'd0);
    chk("reset WB_rd", {27'd0, WB_rd}, 32'd0);
    chk("reset strobe/err", {30'd0, WB_load_regfile, wb_err}, 32'd0);
    chk("reset ready", {31'd0, mem_ready}, 32'd1);
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = 0;
    chk("reset retire_count", retire_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], (i == 5) ? 2 : (i % 2));

    // Response while idle must be ignored.
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk("idle resp strobe/err", {30'd0, WB_load_regfile, wb_err}, 32'd0);
    chk("idle resp ready", {31'd0, mem_ready}, 32'd1);

    // Reset during WAIT_LD drops the load; a late response does nothing.
    @(negedge clk);
    mem_valid = 1'b1; mem_wb_sel = 2'b01; mem_funct3 = 3'b010; mem_rd = 5'd20;
    mem_regwrite = 1'b1; mem_alu_out = 32'h0;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    chk("pre-reset ready low", {31'd0, mem_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset ready", {31'd0, mem_ready}, 32'd1);
    chk("async reset WB_in", WB_in, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    dmem_resp = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk("late resp strobe/err", {30'd0, WB_load_regfile, wb_err}, 32'd0);
    chk("late resp ready", {31'd0, mem_ready}, 32'd1);

    // Three retires after reset.
    for (int i = 0; i < 3; i++) run_vec(vecs[i], 0);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_count", retire_count, exp_cnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
